// File: rtl/timer_ctrl.sv
// Programmable up-counting timer with config handshake, start/stop, periodic or one-shot mode.
// Optional step prescaler compiled in with `define TIMER_CTRL_PRESCALE_EN.
module timer_ctrl #(
   parameter int WIDTH     = 8,
   parameter int PRE_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [WIDTH-1:0]     cfg_period,
   input  logic                 cfg_oneshot,
   input  logic [PRE_WIDTH-1:0] cfg_prescale,
   input  logic                 start,
   input  logic                 stop,
   output logic [WIDTH-1:0]     count,
   output logic                 running,
   output logic                 tick,
   output logic                 done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_count, w_count_nxt;
   logic [WIDTH-1:0] r_period;
   logic             r_oneshot;
   logic             r_tick, w_tick_nxt;
   logic             r_done, w_done_nxt;
   logic             w_cfg_acc;
   logic             w_step;

   assign cfg_ready = (r_state != S_RUN);
   assign running   = (r_state == S_RUN);
   assign w_cfg_acc = cfg_valid && cfg_ready;
   assign count     = r_count;
   assign tick      = r_tick;
   assign done      = r_done;

`ifdef TIMER_CTRL_PRESCALE_EN
   logic [PRE_WIDTH-1:0] r_prescale, r_pre_cnt, w_pre_nxt;

   assign w_step = (r_pre_cnt == r_prescale);

   // Prescaler restarts from zero on any control event so the first step is a full interval away.
   always_comb begin
      w_pre_nxt = r_pre_cnt;
      if (w_cfg_acc) begin
         w_pre_nxt = '0;
      end else if (r_state == S_RUN) begin
         if (stop || start || w_step) w_pre_nxt = '0;
         else                         w_pre_nxt = r_pre_cnt + 1'b1;
      end else if (start) begin
         w_pre_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prescale <= '0;
         r_pre_cnt  <= '0;
      end else begin
         r_pre_cnt <= w_pre_nxt;
         if (w_cfg_acc) r_prescale <= cfg_prescale;
      end
   end
`else
   logic w_unused_prescale;

   assign w_step            = 1'b1;
   assign w_unused_prescale = ^cfg_prescale;
`endif

   // Config accept has priority over start; in RUN, stop beats start.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_tick_nxt  = 1'b0;
      w_done_nxt  = r_done;
      if (w_cfg_acc) begin
         w_state_nxt = S_IDLE;
         w_count_nxt = '0;
         w_done_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (stop) begin
                  w_state_nxt = S_IDLE;
               end else if (start) begin
                  w_count_nxt = '0;
               end else if (w_step) begin
                  if (r_count == r_period) begin
                     w_count_nxt = '0;
                     w_tick_nxt  = 1'b1;
                     if (r_oneshot) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                     end
                  end else begin
                     w_count_nxt = r_count + 1'b1;
                  end
               end
            end
            default: begin
               if (start) begin
                  w_state_nxt = S_RUN;
                  w_count_nxt = '0;
                  w_done_nxt  = 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_period  <= '0;
         r_oneshot <= 1'b0;
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_tick  <= w_tick_nxt;
         r_done  <= w_done_nxt;
         if (w_cfg_acc) begin
            r_period  <= cfg_period;
            r_oneshot <= cfg_oneshot;
         end
      end
   end

endmodule
